// File: rtl/core_if_ifu_pkg.sv
// Shared widths, opcodes and immediate decoders for the instruction fetch unit.
package core_if_ifu_pkg;

    localparam int CORE_PC_WIDTH   = 32;
    localparam int CORE_INST_WIDTH = 32;

    localparam logic [6:0] CORE_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] CORE_OPC_BRANCH = 7'b1100011;

    function automatic logic [CORE_PC_WIDTH-1:0] jal_imm(input logic [CORE_INST_WIDTH-1:0] inst);
        return {{(CORE_PC_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [CORE_PC_WIDTH-1:0] branch_imm(input logic [CORE_INST_WIDTH-1:0] inst);
        return {{(CORE_PC_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/core_if_bpu.sv
// Static branch predictor: JAL and backward conditional branches are taken.
module core_if_bpu
    import core_if_ifu_pkg::*;
(
    input  logic [CORE_INST_WIDTH-1:0] inst,
    input  logic [CORE_PC_WIDTH-1:0]   pc,
    output logic                       taken,
    output logic [CORE_PC_WIDTH-1:0]   target
);

    logic is_jal;
    logic is_branch;

    always_comb begin
        is_jal    = (inst[6:0] == CORE_OPC_JAL);
        is_branch = (inst[6:0] == CORE_OPC_BRANCH);
        taken     = is_jal | (is_branch & inst[31]);
        target    = pc + (is_jal ? jal_imm(inst) : branch_imm(inst));
    end

endmodule

// File: rtl/core_if_ifu.sv
// Instruction fetch unit: issues in-order fetches, tags responses with their PC,
// applies static prediction and hands instructions to decode over valid/ready.
module core_if_ifu
    import core_if_ifu_pkg::*;
#(
    parameter logic [CORE_PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
    parameter int                       OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ifu_req_valid,
    input  logic                       ifu_req_ready,
    output logic [CORE_PC_WIDTH-1:0]   ifu_req_addr,
    input  logic                       ifu_rsp_valid,
    output logic                       ifu_rsp_ready,
    input  logic [CORE_INST_WIDTH-1:0] ifu_rsp_inst,
    input  logic                       redirect_valid,
    input  logic [CORE_PC_WIDTH-1:0]   redirect_pc,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [CORE_PC_WIDTH-1:0]   o_pc,
    output logic [CORE_INST_WIDTH-1:0] o_inst,
    output logic                       o_branch_predict
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [CORE_PC_WIDTH-1:0]   pc_q, pc_d;
    logic [CORE_PC_WIDTH-1:0]   fifo_mem_q [OUTSTANDING];
    logic [CORE_PC_WIDTH-1:0]   fifo_mem_d [OUTSTANDING];
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;
    logic                       valid_q, valid_d;
    logic [CORE_PC_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic [CORE_INST_WIDTH-1:0] out_inst_q, out_inst_d;
    logic                       out_bp_q, out_bp_d;

    logic                       credit_ok;
    logic                       rsp_fire, drop_fire, live_fire;
    logic                       req_fire, pred_redirect, flush;
    logic [CORE_PC_WIDTH-1:0]   head_pc;
    logic                       bpu_taken;
    logic [CORE_PC_WIDTH-1:0]   bpu_target;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_pc = fifo_mem_q[rd_ptr_q];

    core_if_bpu u_bpu (
        .inst   (ifu_rsp_inst),
        .pc     (head_pc),
        .taken  (bpu_taken),
        .target (bpu_target)
    );

    // Dropped responses still occupy a memory slot, so they count against credit.
    always_comb begin
        credit_ok     = ({1'b0, fifo_cnt_q} + {1'b0, drop_cnt_q}) < (CNT_W + 1)'(OUTSTANDING);
        ifu_rsp_ready = (drop_cnt_q != '0) | ~valid_q | ready_out;
        rsp_fire      = ifu_rsp_valid & ifu_rsp_ready;
        drop_fire     = rsp_fire & (drop_cnt_q != '0);
        live_fire     = rsp_fire & (drop_cnt_q == '0);
        pred_redirect = live_fire & bpu_taken & ~redirect_valid;
        flush         = redirect_valid | pred_redirect;
        ifu_req_valid = ~rst & credit_ok & ~flush;
        ifu_req_addr  = pc_q;
        req_fire      = ifu_req_valid & ifu_req_ready;
    end

    always_comb begin
        pc_d       = pc_q;
        fifo_mem_d = fifo_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            pc_d       = redirect_valid ? redirect_pc : bpu_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fifo_cnt_d = '0;
            drop_cnt_d = drop_cnt_q + fifo_cnt_q - CNT_W'(live_fire)
                         - CNT_W'(redirect_valid & drop_fire);
        end else begin
            if (req_fire) begin
                fifo_mem_d[wr_ptr_q] = pc_q;
                wr_ptr_d             = next_ptr(wr_ptr_q);
                pc_d                 = pc_q + CORE_PC_WIDTH'(4);
            end
            if (live_fire) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            fifo_cnt_d = fifo_cnt_q + CNT_W'(req_fire) - CNT_W'(live_fire);
            if (drop_fire) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    // A predicting instruction is still presented; an external redirect kills it.
    always_comb begin
        valid_d    = valid_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        out_bp_d   = out_bp_q;
        if (redirect_valid) begin
            valid_d = 1'b0;
        end else if (live_fire) begin
            valid_d    = 1'b1;
            out_pc_d   = head_pc;
            out_inst_d = ifu_rsp_inst;
            out_bp_d   = bpu_taken;
        end else if (valid_q & ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            for (int i = 0; i < OUTSTANDING; i++) fifo_mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            drop_cnt_q <= '0;
            valid_q    <= 1'b0;
            out_pc_q   <= '0;
            out_inst_q <= '0;
            out_bp_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            fifo_mem_q <= fifo_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            valid_q    <= valid_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            out_bp_q   <= out_bp_d;
        end
    end

    assign valid_out        = valid_q;
    assign o_pc             = out_pc_q;
    assign o_inst           = out_inst_q;
    assign o_branch_predict = out_bp_q;

endmodule
